// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_pkg
//  Purpose  : Shared definitions for the ALU issue controller: opcode
//             constants, FSM state encoding, instruction field positions and
//             small decode helpers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_issue_ctrl_pkg;

    // Instruction field bit positions inside the instruction word
    localparam int OPC_HI = 19;
    localparam int OPC_LO = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 12;
    localparam int RS1_HI = 11;
    localparam int RS1_LO = 8;
    localparam int RS2_HI = 7;
    localparam int RS2_LO = 4;
    localparam int IMM_HI = 11;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = IMM_HI - IMM_LO + 1;

    // Width of the ALU function code
    localparam int FUNC_W = 4;

    // Opcodes; 0..7 map one-to-one onto the ALU func code
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_MULT = 4'd5;
    localparam logic [3:0] OP_DIV  = 4'd6;
    localparam logic [3:0] OP_REM  = 4'd7;
    localparam logic [3:0] OP_LDI  = 4'd8;
    localparam logic [3:0] OP_NOP  = 4'd9;

    // Controller FSM encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // Opcodes that go through the external ALU
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

    // Opcodes whose divisor must be non-zero
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Opcodes 10..15 are not defined
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op > OP_NOP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_if
//  Purpose  : Bundles the instruction valid/ready handshake and the ALU
//             operand/result bus seen by the issue controller.
//  Ports    : slave  - the controller (consumes instructions, drives the ALU)
//             master - the environment (instruction source plus ALU)
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if #(
    parameter int DW = 20
);
    import alu_issue_ctrl_pkg::*;

    // Instruction handshake
    logic              instr_valid;
    logic              instr_ready;
    logic [DW-1:0]     instr;

    // ALU bus: registered operands out, combinational result back
    logic [DW-1:0]     alu_in1;
    logic [DW-1:0]     alu_in2;
    logic [FUNC_W-1:0] alu_func;
    logic [DW-1:0]     alu_ans;
    logic              alu_zf;

    modport slave (
        input  instr_valid,
        input  instr,
        input  alu_ans,
        input  alu_zf,
        output instr_ready,
        output alu_in1,
        output alu_in2,
        output alu_func
    );

    modport master (
        output instr_valid,
        output instr,
        output alu_ans,
        output alu_zf,
        input  instr_ready,
        input  alu_in1,
        input  alu_in2,
        input  alu_func
    );

endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl_reg_file_16x20.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_16x20
//  Purpose  : NREG x DW register file with two combinational read ports, a
//             combinational debug read port and one synchronous write port.
//             Entry 0 is held at zero and ignores writes.
//  Ports    : clk, rst_n        - clock, synchronous active-low reset
//             we/waddr/wdata    - write port (rising edge)
//             raddr1/rdata1     - operand read port 1
//             raddr2/rdata2     - operand read port 2
//             dbg_addr/dbg_data - debug read port
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_16x20 #(
    parameter int DW   = 20,
    parameter int NREG = 16,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] regs [NREG];

    // Entry 0 is only ever loaded by reset, so it always reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (we && (waddr == AW'(i))) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    assign rdata1   = regs[raddr1];
    assign rdata2   = regs[raddr2];
    assign dbg_data = regs[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Multi-cycle issue controller for an external combinational ALU.
//             Accepts one instruction per four cycles, reads operands from
//             the internal register file, drives registered ALU operands,
//             captures the result and writes it back, keeping sticky
//             divide-by-zero and illegal-opcode flags.
//  Ports    : clk, rst_n  - clock, synchronous active-low reset
//             bus         - instruction handshake and ALU bus (slave view)
//             done        - one-cycle pulse when an instruction retires
//             zf_flag     - zero flag of the last retired ALU operation
//             dz_err      - sticky divide/remainder-by-zero flag
//             ill_err     - sticky illegal-opcode flag
//             dbg_addr    - register file debug read address
//             dbg_data    - register file debug read data (r0 reads 0)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DW   = 20,
    parameter int NREG = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_ctrl_if.slave      bus,
    output logic                 done,
    output logic                 zf_flag,
    output logic                 dz_err,
    output logic                 ill_err,
    input  logic [3:0]           dbg_addr,
    output logic [DW-1:0]        dbg_data
);

    state_t state;
    state_t state_nx;

    // Latched instruction and its decoded fields
    logic [DW-1:0]    instr_q;
    logic [3:0]       op;
    logic [3:0]       rd;
    logic [3:0]       rs1;
    logic [3:0]       rs2;
    logic [IMM_W-1:0] imm;

    // Result captured from the ALU in EXEC
    logic [DW-1:0]    res_q;
    logic             zf_q;

    // Register file connections
    logic [DW-1:0]    rd1_data;
    logic [DW-1:0]    rd2_data;
    logic [DW-1:0]    wr_data;
    logic             wr_en;
    logic             div_zero;

    assign op  = instr_q[OPC_HI:OPC_LO];
    assign rd  = instr_q[RD_HI:RD_LO];
    assign rs1 = instr_q[RS1_HI:RS1_LO];
    assign rs2 = instr_q[RS2_HI:RS2_LO];
    assign imm = instr_q[IMM_HI:IMM_LO];

    // The divisor test uses the operand the ALU actually saw, not a fresh
    // register read, so it is consistent with the captured result.
    assign div_zero = is_div_op(op) && (bus.alu_in2 == '0);

    always_comb begin
        wr_en   = 1'b0;
        wr_data = res_q;
        if (state == S_WB) begin
            if (op == OP_LDI) begin
                wr_en   = 1'b1;
                wr_data = {{(DW-IMM_W){1'b0}}, imm};
            end else if (is_alu_op(op) && !div_zero) begin
                wr_en   = 1'b1;
            end
        end
    end

    reg_file_16x20 #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (4)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wr_en),
        .waddr    (rd),
        .wdata    (wr_data),
        .raddr1   (rs1),
        .rdata1   (rd1_data),
        .raddr2   (rs2),
        .rdata2   (rd2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake/retire outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nx        = state;
        bus.instr_ready = 1'b0;
        done            = 1'b0;
        case (state)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_nx = S_READ;
                end
            end
            S_READ: state_nx = S_EXEC;
            S_EXEC: state_nx = S_WB;
            S_WB: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: instruction latch, ALU operand registers, result capture
    // and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q      <= '0;
            bus.alu_in1  <= '0;
            bus.alu_in2  <= '0;
            bus.alu_func <= '0;
            res_q        <= '0;
            zf_q         <= 1'b0;
            zf_flag      <= 1'b0;
            dz_err       <= 1'b0;
            ill_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                    end
                end
                S_READ: begin
                    bus.alu_in1  <= rd1_data;
                    bus.alu_in2  <= rd2_data;
                    bus.alu_func <= is_alu_op(op) ? op : 4'd0;
                end
                S_EXEC: begin
                    res_q <= bus.alu_ans;
                    zf_q  <= bus.alu_zf;
                end
                S_WB: begin
                    if (is_alu_op(op)) begin
                        if (div_zero) begin
                            dz_err <= 1'b1;
                        end else begin
                            zf_flag <= zf_q;
                        end
                    end else if (is_illegal_op(op)) begin
                        ill_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
